exc_ctrl: RTL and testbench
===========================

Name: exc_ctrl

Overview:
Trap/exception controller that consumes the ALU's div_by_zero and overflow flags plus an external interrupt line at the EX stage. Decides trap entry, saves mepc/mcause, and issues one-cycle flush plus PC redirect to mtvec. Handles mret return to mepc. Holds the machine trap CSRs used by the handler.

Parameters:
MTVEC_RESET, 32'h0000_1000, reset value of mtvec.
XLEN, 32, data/PC width (only 32 supported).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
ex_valid  in  1  EX stage holds a real (non-bubble) instruction
ex_pc  in  32  PC of the EX instruction
ex_div_by_zero  in  1  ALU divide-by-zero flag
ex_overflow  in  1  ALU signed add/sub overflow flag
ex_mret  in  1  EX instruction is mret
ext_irq  in  1  level-sensitive external interrupt, already synchronised
csr_we  in  1  CSR write strobe from EX
csr_addr  in  12  CSR address
csr_wdata  in  32  CSR write data
csr_rdata  out  32  combinational CSR read data
flush  out  1  kill IF/ID/EX, one-cycle pulse
redirect_valid  out  1  PC mux select, one-cycle pulse, coincident with flush
redirect_pc  out  32  target PC
in_handler  out  1  high while in state HANDLER

Behaviour:
- Reset values: state IDLE; flush=0; redirect_valid=0; redirect_pc=0; in_handler=0; mstatus.MIE=0, MPIE=0; mtvec=MTVEC_RESET; mepc=0; mcause=0.
- CSRs: mstatus 0x300 (MIE bit3, MPIE bit7, other bits read 0). mtvec 0x305 (bits[1:0] forced 0). mepc 0x341 (bit0 forced 0). mcause 0x342 (read-only to software; writes ignored). Unmapped addresses read 0 and ignore writes.
- Trap condition, evaluated only when ex_valid=1 and state is IDLE or HANDLER. Priority: div_by_zero > overflow > ext_irq.
- ext_irq is taken only when MIE=1; it is never taken in HANDLER because MIE=0 there.
- Cause codes: div_by_zero 32'd24; overflow 32'd25; external interrupt 32'h8000_000B.
- Trap entry at the edge ending cycle N, where cycle N has the condition true:
  - mepc<=ex_pc; mcause<=code; MPIE<=MIE; MIE<=0; state<=TRAP.
  - The faulting or interrupted instruction does not commit.
- State TRAP (cycle N+1): flush=1, redirect_valid=1, redirect_pc=mtvec; next state HANDLER. All ex_* inputs are ignored in TRAP.
- State HANDLER: in_handler=1. A further exception re-enters TRAP and overwrites mepc/mcause (nested fault, no stacking).
- mret in HANDLER with ex_valid=1 and no exception: MIE<=MPIE; MPIE<=1; state<=RETURN.
- State RETURN: flush=1, redirect_valid=1, redirect_pc=mepc; next state IDLE.
- mret in IDLE is a no-op with no redirect.
- Latency: exactly 1 cycle from the condition to flush/redirect. Outputs are registered or decoded from state only.
- Simultaneous CSR write and trap entry in the same cycle: trap updates win and the CSR write is dropped.
- Simultaneous mret and exception: the exception wins.
- rst asserted in any state: next edge returns all state to reset values. A pending flush is cancelled.
- ext_irq held high stays pending and is taken on the first valid IDLE cycle with MIE=1.

Optional Feature:
EXC_COUNT_EN: when defined, a 32-bit trap counter is readable at CSR 0xB03. It increments on each TRAP entry, saturates at 32'hFFFF_FFFF, is cleared by rst, and is writable via CSR. When undefined, 0xB03 reads 0, writes are ignored, and no counter flops are generated.

Decomposition:
- Shared package: CSR address constants, cause codes, 2-bit state encoding (IDLE=0, TRAP=1, HANDLER=2, RETURN=3), MIE/MPIE bit indices.
- One sub-module, exc_csr_file: holds mstatus/mtvec/mepc/mcause (and the counter), with read mux and write masking. exc_ctrl keeps the FSM and priority logic.

Test Plan:
- Reset, then read CSRs -> mtvec=0x1000, mepc=0, mcause=0, mstatus=0; flush=0.
- MIE=1; ex_valid=1, ex_pc=0x200, ex_div_by_zero=1 -> next cycle flush=1, redirect_pc=0x1000; mepc=0x200; mcause=24; MIE=0; in_handler=1 the cycle after.
- In HANDLER, ex_mret=1 -> next cycle redirect_pc=0x200, flush=1; then IDLE with MIE=1.
- ext_irq=1 with MIE=0 -> no trap. Write mstatus=0x8 -> trap with mcause=0x8000_000B, mepc=current ex_pc.
- Same cycle: ex_overflow=1, ext_irq=1, csr_we to mtvec -> mcause=25, mtvec unchanged. Second overflow in HANDLER at pc 0x1004 -> mepc=0x1004.
- rst pulsed in TRAP -> flush drops the next cycle and state is IDLE. With EXC_COUNT_EN, 3 traps -> 0xB03 reads 3.

Source files
------------

// File: rtl/exc_ctrl_pkg.sv
// exc_ctrl_pkg: shared CSR addresses, cause codes, mstatus bit indices and FSM states
package exc_ctrl_pkg;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_TRAPCNT = 12'hB03;
    localparam logic [31:0] CAUSE_DIV0  = 32'd24;
    localparam logic [31:0] CAUSE_OVF   = 32'd25;
    localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRAP    = 2'd1,
        HANDLER = 2'd2,
        RETURN  = 2'd3
    } state_t;
endpackage

// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: EX-stage flags, CSR port and flush/redirect outputs of the trap controller
interface exc_ctrl_if;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_div_by_zero;
    logic        ex_overflow;
    logic        ex_mret;
    logic        ext_irq;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        in_handler;
    modport master (
        output ex_valid, ex_pc, ex_div_by_zero, ex_overflow, ex_mret, ext_irq,
               csr_we, csr_addr, csr_wdata,
        input  csr_rdata, flush, redirect_valid, redirect_pc, in_handler
    );
    modport slave (
        input  ex_valid, ex_pc, ex_div_by_zero, ex_overflow, ex_mret, ext_irq,
               csr_we, csr_addr, csr_wdata,
        output csr_rdata, flush, redirect_valid, redirect_pc, in_handler
    );
endinterface

// File: rtl/exc_ctrl_csr_file.sv
// exc_csr_file: machine trap CSRs with read mux and write masking; EXC_COUNT_EN adds a trap counter at 0xB03
module exc_csr_file
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [11:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        trap,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic        mret,
    output logic        mie,
    output logic [31:0] mtvec,
    output logic [31:0] mepc
);
    logic        mpie;
    logic [31:0] mcause, mstatus, cnt;
    always_comb begin
        mstatus = '0;
        mstatus[MIE_BIT] = mie;
        mstatus[MPIE_BIT] = mpie;
    end
    // Trap entry has priority over any software write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mie    <= 1'b0;
            mpie   <= 1'b0;
            mtvec  <= {MTVEC_RESET[31:2], 2'b00};
            mepc   <= '0;
            mcause <= '0;
        end else if (trap) begin
            mepc   <= {trap_pc[31:1], 1'b0};
            mcause <= trap_cause;
            mpie   <= mie;
            mie    <= 1'b0;
        end else begin
            if (we && addr == CSR_MSTATUS) begin
                mie  <= wdata[MIE_BIT];
                mpie <= wdata[MPIE_BIT];
            end
            if (we && addr == CSR_MTVEC) mtvec <= {wdata[31:2], 2'b00};
            if (we && addr == CSR_MEPC) mepc <= {wdata[31:1], 1'b0};
            if (mret) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end
        end
    end
`ifdef EXC_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (trap) cnt <= cnt + {31'b0, ~&cnt};
        else if (we && addr == CSR_TRAPCNT) cnt <= wdata;
    end
`else
    assign cnt = '0;
`endif
    assign rdata = addr == CSR_MSTATUS ? mstatus :
                   addr == CSR_MTVEC   ? mtvec   :
                   addr == CSR_MEPC    ? mepc    :
                   addr == CSR_MCAUSE  ? mcause  :
                   addr == CSR_TRAPCNT ? cnt     : '0;
endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: EX-stage trap/mret controller driving flush and PC redirect (EXC_COUNT_EN enables trap counter)
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_1000,
    parameter int          XLEN        = 32
) (
    input logic clk,
    input logic rst,
    exc_ctrl_if.slave bus
);
    state_t          state, state_n;
    logic            live, take, mret_take, mie, csr_we;
    logic [XLEN-1:0] cause, mtvec, mepc;
    assign live      = bus.ex_valid && (state == IDLE || state == HANDLER);
    assign take      = live && (bus.ex_div_by_zero || bus.ex_overflow || (bus.ext_irq && mie));
    assign cause     = bus.ex_div_by_zero ? CAUSE_DIV0 : bus.ex_overflow ? CAUSE_OVF : CAUSE_EXT;
    assign mret_take = live && state == HANDLER && bus.ex_mret && !take;
    // The EX instruction is being flushed during TRAP/RETURN, so its CSR write must not land.
    assign csr_we    = bus.csr_we && (state == IDLE || state == HANDLER);
    exc_csr_file #(.MTVEC_RESET(MTVEC_RESET)) u_csr (
        .clk       (clk),
        .rst       (rst),
        .we        (csr_we),
        .addr      (bus.csr_addr),
        .wdata     (bus.csr_wdata),
        .rdata     (bus.csr_rdata),
        .trap      (take),
        .trap_cause(cause),
        .trap_pc   (bus.ex_pc),
        .mret      (mret_take),
        .mie       (mie),
        .mtvec     (mtvec),
        .mepc      (mepc)
    );
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n            = state;
        bus.flush          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.in_handler     = 1'b0;
        case (state)
            IDLE: state_n = take ? TRAP : IDLE;
            TRAP: begin
                bus.flush          = 1'b1;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = mtvec;
                state_n            = HANDLER;
            end
            HANDLER: begin
                bus.in_handler = 1'b1;
                state_n        = take ? TRAP : mret_take ? RETURN : HANDLER;
            end
            RETURN: begin
                bus.flush          = 1'b1;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = mepc;
                state_n            = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed plus random stimulus against a behavioural trap model with a redirect scoreboard
module tb_exc_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    exc_ctrl_if bus();
    exc_ctrl #(.MTVEC_RESET(32'h0000_1000), .XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    bit armed = 1'b0;
    bit m_mie, m_mpie, m_in_h, m_redir, m_to_h;
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_cnt;
    logic [31:0] exp_q[$];
    logic [11:0] addrs[7] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hB03, 12'h123, 12'h344};

    function automatic logic [31:0] mread(logic [11:0] a);
        case (a)
            12'h300: return {24'b0, m_mpie, 3'b0, m_mie, 3'b0};
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
`ifdef EXC_COUNT_EN
            12'hB03: return m_cnt;
`endif
            default: return 32'h0;
        endcase
    endfunction

    // Applies one clock edge of architectural behaviour to the model.
    task automatic model_step();
        bit op, ret;
        if (rst) begin
            m_mie = 0; m_mpie = 0; m_in_h = 0; m_redir = 0; m_to_h = 0;
            m_mtvec = 32'h1000; m_mepc = 0; m_mcause = 0; m_cnt = 0;
            exp_q.delete();
        end else if (m_redir) begin
            m_redir = 0;
            m_in_h = m_to_h;
        end else if (bus.ex_valid && (bus.ex_div_by_zero || bus.ex_overflow || (bus.ext_irq && m_mie))) begin
            m_mcause = bus.ex_div_by_zero ? 32'd24 : bus.ex_overflow ? 32'd25 : 32'h8000_000B;
            m_mepc = bus.ex_pc & ~32'h1;
            m_mpie = m_mie;
            m_mie = 0;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            exp_q.push_back(m_mtvec);
            m_redir = 1; m_to_h = 1; m_in_h = 0;
        end else begin
            op = m_mpie;
            ret = bus.ex_valid && bus.ex_mret && m_in_h;
            if (bus.csr_we) begin
                case (bus.csr_addr)
                    12'h300: begin m_mie = bus.csr_wdata[3]; m_mpie = bus.csr_wdata[7]; end
                    12'h305: m_mtvec = bus.csr_wdata & ~32'h3;
                    12'h341: m_mepc = bus.csr_wdata & ~32'h1;
                    12'hB03: m_cnt = bus.csr_wdata;
                    default: ;
                endcase
            end
            if (ret) begin
                m_mie = op;
                m_mpie = 1;
                exp_q.push_back(m_mepc);
                m_redir = 1; m_to_h = 0; m_in_h = 0;
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            logic exp_r;
            exp_r = exp_q.size() != 0;
            chk("redirect_valid", 32'(bus.redirect_valid), 32'(exp_r));
            chk("flush", 32'(bus.flush), 32'(exp_r));
            if (exp_r) chk("redirect_pc", bus.redirect_pc, exp_q.pop_front());
            chk("in_handler", 32'(bus.in_handler), 32'(m_in_h));
            chk($sformatf("csr_rdata@%h", bus.csr_addr), bus.csr_rdata, mread(bus.csr_addr));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clr();
        bus.ex_valid = 0; bus.ex_div_by_zero = 0; bus.ex_overflow = 0;
        bus.ex_mret = 0; bus.ext_irq = 0; bus.csr_we = 0; bus.csr_wdata = 0;
    endtask

    task automatic wr(logic [11:0] a, logic [31:0] d);
        bus.csr_we = 1; bus.csr_addr = a; bus.csr_wdata = d;
    endtask

    task automatic ex_trap(logic dz, logic ov, logic [31:0] pc);
        bus.ex_valid = 1; bus.ex_div_by_zero = dz; bus.ex_overflow = ov; bus.ex_pc = pc;
        tick(); clr(); tick(); tick();
    endtask

    task automatic do_mret();
        bus.ex_valid = 1; bus.ex_mret = 1;
        tick(); clr(); tick(); tick();
    endtask

    initial begin
        clr();
        bus.ex_pc = 0;
        bus.csr_addr = 12'h305;
        tick(); armed = 1; tick(); rst = 0;
        bus.csr_addr = 12'h341; tick();
        bus.csr_addr = 12'h342; tick();
        bus.csr_addr = 12'h300; tick();
        wr(12'h300, 32'h8); tick(); clr(); tick();
        bus.csr_addr = 12'h341;
        ex_trap(1, 0, 32'h200);
        bus.csr_addr = 12'h342; tick();
        bus.csr_addr = 12'h300;
        do_mret();
        wr(12'h300, 32'h0); tick(); clr();
        bus.ext_irq = 1; bus.ex_valid = 1; bus.ex_pc = 32'h300; tick(); tick();
        wr(12'h300, 32'h8); bus.ex_pc = 32'h304; tick();
        bus.csr_we = 0; bus.ex_pc = 32'h308; bus.csr_addr = 12'h342; tick();
        clr(); tick(); tick();
        bus.csr_addr = 12'h341;
        do_mret();
        bus.ext_irq = 1; wr(12'h305, 32'h4000);
        bus.csr_addr = 12'h305;
        ex_trap(0, 1, 32'h400);
        bus.csr_addr = 12'h341;
        ex_trap(0, 1, 32'h1004);
        bus.ex_valid = 1; bus.ex_div_by_zero = 1; bus.ex_pc = 32'h500; tick();
        clr(); rst = 1; tick(); rst = 0; tick(); tick();
        bus.csr_addr = 12'hB03;
        for (int k = 0; k < 3; k++) begin
            ex_trap(1, 0, 32'h600 + 32'(k * 4));
            do_mret();
        end
        tick();
        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(0, 299) == 0;
            bus.ex_valid = $urandom_range(0, 3) != 0;
            bus.ex_pc = $urandom & 32'hFFFF_FFFC;
            bus.ex_div_by_zero = $urandom_range(0, 15) == 0;
            bus.ex_overflow = $urandom_range(0, 11) == 0;
            bus.ex_mret = $urandom_range(0, 4) == 0;
            bus.ext_irq = $urandom_range(0, 7) == 0;
            bus.csr_we = $urandom_range(0, 3) == 0;
            bus.csr_addr = addrs[$urandom_range(0, 6)];
            bus.csr_wdata = $urandom;
            tick();
        end
        rst = 0; clr(); tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
